// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the fetch-side instruction cache.
//   - icacheState_e : responder FSM states (idle lookup, line fill, post-fill retry, error)
//   - fetchAddr_t   : byte address split into line address, word-in-line and odd-byte bit
//   - IDX_W / TAG_W / WORD_W : default geometry (32 lines of 4 16-bit words)
//   - splitAddr / memWordAddr : address field extract and backing-address build helpers
package icache_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned WORD_W = 2;
   // Line address = byte address without word-in-line and byte-in-word bits.
   localparam int unsigned LINE_W = ADDR_W - WORD_W - 1;
   localparam int unsigned IDX_W  = 5;
   localparam int unsigned TAG_W  = LINE_W - IDX_W;

   localparam logic [DATA_W-1:0] DATA_ZERO = '0;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [WORD_W-1:0] WORD_ZERO = '0;
   localparam logic [WORD_W-1:0] LAST_WORD = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StRetry,
      StError
   } icacheState_e;

   typedef struct packed {
      logic [LINE_W-1:0] line;
      logic [WORD_W-1:0] word;
      logic              odd;
   } fetchAddr_t;

   function automatic fetchAddr_t splitAddr(input logic [ADDR_W-1:0] a);
      return fetchAddr_t'(a);
   endfunction

   function automatic logic [ADDR_W-1:0] memWordAddr(input logic [LINE_W-1:0] line,
                                                     input logic [WORD_W-1:0] word);
      return {line, word, 1'b0};
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays of the direct-mapped instruction cache.
//   clk, rst_n          : clock, asynchronous active-low reset (clears valid bits only)
//   rdIdx, rdWord       : lookup index and word; rdValid/rdTag/rdData are combinational
//   wrEn, wrIdx, wrWord, wrData : write one fill word into the data array
//   tagWrEn, wrTag      : write the tag of line wrIdx and mark it valid
//   clrEn               : invalidate line wrIdx (aborted fill)
module icache_line_store
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_W  = IDX_W,
   parameter int unsigned TAG_BITS = TAG_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INDEX_W-1:0]  rdIdx,
   input  logic [WORD_W-1:0]   rdWord,
   output logic                rdValid,
   output logic [TAG_BITS-1:0] rdTag,
   output logic [DATA_W-1:0]   rdData,
   input  logic                wrEn,
   input  logic [INDEX_W-1:0]  wrIdx,
   input  logic [WORD_W-1:0]   wrWord,
   input  logic [DATA_W-1:0]   wrData,
   input  logic                tagWrEn,
   input  logic [TAG_BITS-1:0] wrTag,
   input  logic                clrEn
);

   localparam int unsigned Lines = 2 ** INDEX_W;
   localparam int unsigned Words = 2 ** (INDEX_W + WORD_W);

   logic [Lines-1:0]    validQ;
   logic [TAG_BITS-1:0] tagArr  [Lines];
   logic [DATA_W-1:0]   dataArr [Words];

   assign rdValid = validQ[rdIdx];
   assign rdTag   = tagArr[rdIdx];
   assign rdData  = dataArr[{rdIdx, rdWord}];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validQ <= '0;
      end else if (tagWrEn) begin
         validQ[wrIdx] <= 1'b1;
      end else if (clrEn) begin
         validQ[wrIdx] <= 1'b0;
      end
   end

   // Tag and data storage carry no reset; validQ alone qualifies their contents.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         dataArr[{wrIdx, wrWord}] <= wrData;
      end
      if (tagWrEn) begin
         tagArr[wrIdx] <= wrTag;
      end
   end

endmodule

// File: rtl/icache_resp.sv
// icache_resp: responder side of the fetch <-> I-cache interface. Direct-mapped, read-only
// cache of 4-word lines. Hits answer combinationally in the request cycle; misses stall
// and fill the line word by word from backing memory, then retry the lookup.
//   clk, rst_n            : clock, asynchronous active-low reset
//   Addr, Rd, Wr          : fetch request (Wr is always illegal here); DataIn is ignored
//   createdump            : freeze, no new fill is started while high
//   DataOut, Done, Stall, CacheHit, err : fetch response
//   mem_req, mem_addr     : backing read request (registered), held until mem_rvalid
//   mem_rdata, mem_rvalid, mem_err : backing read response
// Optional feature: define ICACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module icache_resp
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_W = IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] DataIn,
   input  logic              Rd,
   input  logic              Wr,
   input  logic              createdump,
   output logic [DATA_W-1:0] DataOut,
   output logic              Done,
   output logic              Stall,
   output logic              CacheHit,
   output logic              err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   input  logic              mem_err
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);

   localparam int unsigned TagBits = LINE_W - INDEX_W;

   icacheState_e      stateQ;
   logic [LINE_W-1:0] fillLineQ;
   logic [WORD_W-1:0] fillWordQ;
   logic [WORD_W-1:0] nextWord;

   fetchAddr_t         req;
   logic [INDEX_W-1:0] reqIdx;
   logic [TagBits-1:0] reqTag;
   logic [INDEX_W-1:0] fillIdx;
   logic [TagBits-1:0] fillTag;

   logic               lineValid;
   logic [TagBits-1:0] lineTag;
   logic [DATA_W-1:0]  lineWord;

   logic lookup;
   logic illegal;
   logic hit;
   logic startFill;
   logic sameLine;
   logic fillAck;
   logic wrEn;
   logic tagWrEn;
   logic clrEn;

   logic unusedDataIn;
   assign unusedDataIn = ^DataIn;

   assign req     = splitAddr(Addr);
   assign reqIdx  = req.line[INDEX_W-1:0];
   assign reqTag  = req.line[LINE_W-1:INDEX_W];
   assign fillIdx = fillLineQ[INDEX_W-1:0];
   assign fillTag = fillLineQ[LINE_W-1:INDEX_W];

   assign nextWord = fillWordQ + WORD_W'(1);

   assign lookup    = (stateQ == StIdle) || (stateQ == StRetry);
   assign illegal   = Wr || (Rd && req.odd);
   assign hit       = Rd && lineValid && (lineTag == reqTag);
   assign startFill = lookup && Rd && !illegal && !hit && !createdump;
   // A retry that lands on the line just filled is still reported as a miss.
   assign sameLine  = (stateQ == StRetry) && (req.line == fillLineQ);

   assign fillAck = (stateQ == StFill) && mem_rvalid;
   assign wrEn    = fillAck && !mem_err;
   assign tagWrEn = wrEn && (fillWordQ == LAST_WORD);
   assign clrEn   = fillAck && mem_err;

   icache_line_store #(
      .INDEX_W  (INDEX_W),
      .TAG_BITS (TagBits)
   ) u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .rdIdx   (reqIdx),
      .rdWord  (req.word),
      .rdValid (lineValid),
      .rdTag   (lineTag),
      .rdData  (lineWord),
      .wrEn    (wrEn),
      .wrIdx   (fillIdx),
      .wrWord  (fillWordQ),
      .wrData  (mem_rdata),
      .tagWrEn (tagWrEn),
      .wrTag   (fillTag),
      .clrEn   (clrEn)
   );

   // Fetch response is combinational so hits complete in the request cycle; it is forced
   // low while reset is asserted so fetch sees an idle cache immediately.
   always_comb begin
      DataOut  = DATA_ZERO;
      Done     = 1'b0;
      Stall    = 1'b0;
      CacheHit = 1'b0;
      err      = 1'b0;
      if (rst_n) begin
         unique case (stateQ)
            StIdle, StRetry: begin
               if (illegal) begin
                  Done = 1'b1;
                  err  = 1'b1;
               end else if (Rd) begin
                  if (hit) begin
                     Done     = 1'b1;
                     CacheHit = !sameLine;
                     DataOut  = lineWord;
                  end else if (!createdump) begin
                     Stall = 1'b1;
                  end
               end
            end
            StFill: begin
               Stall = 1'b1;
            end
            StError: begin
               Done = 1'b1;
               err  = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Fill sequencer. The fill address is latched at the miss, so later Addr changes
   // cannot disturb an in-flight fill; the retry lookup picks up the new Addr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= StIdle;
         fillLineQ <= '0;
         fillWordQ <= WORD_ZERO;
         mem_req   <= 1'b0;
         mem_addr  <= ADDR_ZERO;
      end else begin
         unique case (stateQ)
            StIdle, StRetry: begin
               if (startFill) begin
                  stateQ    <= StFill;
                  fillLineQ <= req.line;
                  fillWordQ <= WORD_ZERO;
                  mem_req   <= 1'b1;
                  mem_addr  <= memWordAddr(req.line, WORD_ZERO);
               end else begin
                  stateQ <= StIdle;
               end
            end
            StFill: begin
               if (mem_rvalid) begin
                  if (mem_err) begin
                     stateQ  <= StError;
                     mem_req <= 1'b0;
                  end else if (fillWordQ == LAST_WORD) begin
                     stateQ  <= StRetry;
                     mem_req <= 1'b0;
                  end else begin
                     fillWordQ <= nextWord;
                     mem_addr  <= memWordAddr(fillLineQ, nextWord);
                  end
               end
            end
            StError: begin
               stateQ <= StIdle;
            end
            default: begin
               stateQ <= StIdle;
            end
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (Done && CacheHit && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
         end
         if (startFill && (miss_cnt != 16'hFFFF)) begin
            miss_cnt <= miss_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Randomised bench for icache_resp. The reference model records, per index, which line
// address is resident (or none); backing memory content is a fixed function of address.
module tb_icache_resp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic        createdump;
   logic [15:0] DataOut;
   logic        Done;
   logic        Stall;
   logic        CacheHit;
   logic        err;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic        mem_err;
`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
`endif

   always #5 clk = ~clk;

   icache_resp dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Addr       (Addr),
      .DataIn     (DataIn),
      .Rd         (Rd),
      .Wr         (Wr),
      .createdump (createdump),
      .DataOut    (DataOut),
      .Done       (Done),
      .Stall      (Stall),
      .CacheHit   (CacheHit),
      .err        (err),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .mem_err    (mem_err)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
`endif
   );

   int vecCnt  = 0;
   int failCnt = 0;

   task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vecCnt++;
      if (got !== exp) begin
         failCnt++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Backing memory: word at byte address 0x0040 is A000, next word A001, and so on.
   function automatic logic [15:0] memVal(input logic [15:0] a);
      logic [15:0] d;
      d = a - 16'h0040;
      return 16'hA000 + {1'b0, d[15:1]};
   endfunction

   // Reference model: resident line address per index, -1 when invalid.
   int cachedLine [32];
   int hitModel  = 0;
   int fillModel = 0;

   function automatic int lineOf(input logic [15:0] a);
      return int'(a[15:3]);
   endfunction

   function automatic int idxOf(input logic [15:0] a);
      return int'(a[7:3]);
   endfunction

   // Memory responder: random latency, occasional stray rvalid while no request is open.
   int          errAt = -1;
   logic [15:0] memLog [$];

   always @(negedge clk) begin
      if (rst_n && mem_req && mem_rvalid) memLog.push_back(mem_addr);
   end

   always @(posedge clk) begin
      #1;
      if (mem_req && $urandom_range(0, 2) != 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = memVal(mem_addr);
         mem_err    = (memLog.size() == errAt);
      end else if (!mem_req && $urandom_range(0, 7) == 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 16'($urandom);
         mem_err    = 1'($urandom_range(0, 1));
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = 16'h0000;
         mem_err    = 1'b0;
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkLog(input logic [15:0] a, input int first, input int n);
      logic [12:0] line;
      logic [1:0]  w;
      line = a[15:3];
      for (int k = 0; k < n; k++) begin
         w = 2'(k);
         if (first + k < memLog.size()) begin
            checkVal("memAddr", memLog[first + k], {line, w, 1'b0});
         end else begin
            checkVal("memAddrMissing", 16'h0000, {line, w, 1'b0});
         end
      end
   endtask

   // Waits for Done while requiring Stall on every intervening cycle.
   task automatic waitDone(input int budget, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         nextCycle();
         @(negedge clk);
         if (Done) seen = 1'b1;
         else checkVal("fillStall", Stall, 1'b1);
      end
      checkVal("doneSeen", seen, 1'b1);
   endtask

   task automatic doReq(input logic [15:0] a, input bit rd, input bit wr, input bit dump,
                        input int errWord);
      bit illegal;
      bit hitM;
      bit seen;
      int expLen;
      illegal    = wr || (rd && a[0]);
      hitM       = (cachedLine[idxOf(a)] == lineOf(a));
      Addr       = a;
      Rd         = rd;
      Wr         = wr;
      createdump = dump;
      errAt      = errWord;
      memLog.delete();
      @(negedge clk);
      if (illegal) begin
         checkVal("illDone", Done, 1'b1);
         checkVal("illErr", err, 1'b1);
         checkVal("illHit", CacheHit, 1'b0);
         checkVal("illData", DataOut, 16'h0000);
         checkVal("illStall", Stall, 1'b0);
         nextCycle();
         checkVal("illMemReq", mem_req, 1'b0);
      end else if (!rd) begin
         checkVal("idleDone", Done, 1'b0);
         checkVal("idleStall", Stall, 1'b0);
         checkVal("idleErr", err, 1'b0);
         nextCycle();
      end else if (hitM) begin
         checkVal("hitDone", Done, 1'b1);
         checkVal("hitFlag", CacheHit, 1'b1);
         checkVal("hitData", DataOut, memVal(a));
         checkVal("hitStall", Stall, 1'b0);
         checkVal("hitErr", err, 1'b0);
         hitModel++;
         nextCycle();
         checkVal("hitMemReq", mem_req, 1'b0);
      end else if (dump) begin
         checkVal("dumpDone", Done, 1'b0);
         checkVal("dumpStall", Stall, 1'b0);
         checkVal("dumpErr", err, 1'b0);
         nextCycle();
         checkVal("dumpMemReq", mem_req, 1'b0);
      end else begin
         checkVal("missStall", Stall, 1'b1);
         checkVal("missDone", Done, 1'b0);
         fillModel++;
         waitDone(200, seen);
         checkVal("fillHit", CacheHit, 1'b0);
         checkVal("fillStallEnd", Stall, 1'b0);
         if (errWord >= 0) begin
            checkVal("memErrFlag", err, 1'b1);
            checkVal("memErrData", DataOut, 16'h0000);
            cachedLine[idxOf(a)] = -1;
            expLen = errWord + 1;
         end else begin
            checkVal("fillErr", err, 1'b0);
            checkVal("fillData", DataOut, memVal(a));
            cachedLine[idxOf(a)] = lineOf(a);
            expLen = 4;
         end
         nextCycle();
         checkVal("logLen", 16'(memLog.size()), 16'(expLen));
         checkLog(a, 0, expLen);
      end
      errAt = -1;
   endtask

   task automatic doRedirect(input logic [15:0] a0, input logic [15:0] a1);
      bit seen;
      bit moved;
      Addr       = a0;
      Rd         = 1'b1;
      Wr         = 1'b0;
      createdump = 1'b0;
      errAt      = -1;
      memLog.delete();
      @(negedge clk);
      checkVal("redirStall", Stall, 1'b1);
      moved = 1'b0;
      seen  = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         nextCycle();
         if (!moved && memLog.size() >= 1) begin
            Addr  = a1;
            moved = 1'b1;
         end
         @(negedge clk);
         if (Done) seen = 1'b1;
         else checkVal("redirFillStall", Stall, 1'b1);
      end
      checkVal("redirDoneSeen", seen, 1'b1);
      checkVal("redirHit", CacheHit, 1'b0);
      checkVal("redirData", DataOut, memVal(a1));
      checkVal("redirErr", err, 1'b0);
      cachedLine[idxOf(a0)] = lineOf(a0);
      cachedLine[idxOf(a1)] = lineOf(a1);
      fillModel += 2;
      nextCycle();
      checkVal("redirLogLen", 16'(memLog.size()), 16'd8);
      checkLog(a0, 0, 4);
      checkLog(a1, 4, 4);
   endtask

   task automatic checkOutputsZero(input string tag);
      checkVal({tag, "Done"}, Done, 1'b0);
      checkVal({tag, "Stall"}, Stall, 1'b0);
      checkVal({tag, "Hit"}, CacheHit, 1'b0);
      checkVal({tag, "Err"}, err, 1'b0);
      checkVal({tag, "Data"}, DataOut, 16'h0000);
      checkVal({tag, "MemReq"}, mem_req, 1'b0);
      checkVal({tag, "MemAddr"}, mem_addr, 16'h0000);
   endtask

   task automatic clearModel();
      for (int i = 0; i < 32; i++) cachedLine[i] = -1;
      hitModel  = 0;
      fillModel = 0;
   endtask

   task automatic doResetMidFill(input logic [15:0] a);
      Addr       = a;
      Rd         = 1'b1;
      Wr         = 1'b0;
      createdump = 1'b0;
      errAt      = -1;
      memLog.delete();
      @(negedge clk);
      checkVal("rstMissStall", Stall, 1'b1);
      for (int n = 0; n < 200 && memLog.size() < 2; n++) nextCycle();
      checkVal("rstReachedWord2", 16'(memLog.size()), 16'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutputsZero("midRst");
      clearModel();
      Rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nextCycle();
   endtask

   initial begin
      bit [4:0]    idxPick [3];
      logic [15:0] a;
      int          r;
      int          ew;
      idxPick[0] = 5'd0;
      idxPick[1] = 5'd1;
      idxPick[2] = 5'd8;
      clearModel();
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      mem_err    = 1'b0;
      rst_n      = 1'b0;
      Addr       = 16'h0040;
      DataIn     = 16'h1234;
      Rd         = 1'b1;
      Wr         = 1'b0;
      createdump = 1'b0;
      #3;
      checkOutputsZero("rst");
      Rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nextCycle();

      doReq(16'h0040, 1'b1, 1'b0, 1'b0, -1);   // cold miss
      doReq(16'h0042, 1'b1, 1'b0, 1'b0, -1);   // same-cycle hit A001
      doReq(16'h1040, 1'b1, 1'b0, 1'b0, -1);   // conflict refill
      doReq(16'h0040, 1'b1, 1'b0, 1'b0, -1);   // evicted, misses again
      doReq(16'h1040, 1'b1, 1'b0, 1'b0, -1);
      doRedirect(16'h0040, 16'h0200);
      doReq(16'h0041, 1'b1, 1'b0, 1'b0, -1);   // odd address
      doReq(16'h0040, 1'b0, 1'b1, 1'b0, -1);   // write
      doReq(16'h0040, 1'b1, 1'b1, 1'b0, -1);   // read and write
      doReq(16'h0040, 1'b0, 1'b0, 1'b0, -1);   // no request
      doReq(16'h1040, 1'b1, 1'b0, 1'b0, -1);
      doReq(16'h0040, 1'b1, 1'b0, 1'b0, 2);    // mem_err on word 2
      doReq(16'h0040, 1'b1, 1'b0, 1'b0, -1);   // line left invalid
      doReq(16'h0046, 1'b1, 1'b0, 1'b1, -1);   // hit served under freeze
      doReq(16'h1046, 1'b1, 1'b0, 1'b1, -1);   // miss under freeze: nothing
      doResetMidFill(16'h1040);
      doReq(16'h0040, 1'b1, 1'b0, 1'b0, -1);

      for (int t = 0; t < 250; t++) begin
         r  = $urandom_range(0, 19);
         a  = {8'($urandom_range(0, 2)), idxPick[$urandom_range(0, 2)],
               2'($urandom_range(0, 3)), (r == 0)};
         ew = (r == 5) ? int'($urandom_range(0, 3)) : -1;
         doReq(a, (r != 1), (r == 2), (r == 4), ew);
      end

`ifdef ICACHE_STATS_EN
      checkVal("hitCnt", hit_cnt, 16'(hitModel));
      checkVal("missCnt", miss_cnt, 16'(fillModel));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, failCnt);
      $finish;
   end

endmodule
